// File: rtl/ghostbus_arb_defs.sv
// ghostbus_arb_defs: shared FSM state and requester id encodings for the ghostbus arbiter
package ghostbus_arb_defs;
  typedef enum logic [1:0] {IDLE, STROBE, RWAIT, ACK} gb_state_t;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/gb_rr_pick2.sv
// gb_rr_pick2: combinational two-way round-robin picker with owner mask
module gb_rr_pick2 import ghostbus_arb_defs::*; (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       grant,
  output logic       valid
);
  logic [1:0] m;
  always_comb begin
    m = req & mask;
    valid = |m;
    grant = &m ? ~last : m[REQ_B];
  end
endmodule

// File: rtl/ghostbus_arbiter.sv
// ghostbus_arbiter: two-requester round-robin ghostbus host arbiter; GHOSTBUS_ARB_LOCK_EN adds a_lock/b_lock bus ownership
module ghostbus_arbiter import ghostbus_arb_defs::*; #(
  parameter int GB_AW = 24,
  parameter int GB_DW = 32,
  parameter int RD_DELAY = 2
) (
  input  logic             gb_clk,
  input  logic             gb_rst,
  input  logic             a_req,
  input  logic             b_req,
  input  logic             a_we,
  input  logic             b_we,
  input  logic [GB_AW-1:0] a_addr,
  input  logic [GB_AW-1:0] b_addr,
  input  logic [GB_DW-1:0] a_wdata,
  input  logic [GB_DW-1:0] b_wdata,
`ifdef GHOSTBUS_ARB_LOCK_EN
  input  logic             a_lock,
  input  logic             b_lock,
`endif
  output logic             a_ack,
  output logic             b_ack,
  output logic [GB_DW-1:0] a_rdata,
  output logic [GB_DW-1:0] b_rdata,
  output logic [GB_AW-1:0] gb_addr,
  output logic [GB_DW-1:0] gb_wdata,
  output logic             gb_wen,
  output logic             gb_rstb,
  input  logic [GB_DW-1:0] gb_rdata
);
  localparam int CW = $clog2(RD_DELAY + 1);
  gb_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic win, last, grant, valid, sel_we;
  logic [1:0] mask;
  gb_rr_pick2 u_pick (
    .req   ({b_req, a_req}),
    .last  (last),
    .mask  (mask),
    .grant (grant),
    .valid (valid)
  );
`ifdef GHOSTBUS_ARB_LOCK_EN
  logic own_v, own, owned;
  assign owned = own_v && (own ? b_lock : a_lock);
  assign mask = owned ? (own ? 2'b10 : 2'b01) : 2'b11;
  always_ff @(posedge gb_clk)
    if (gb_rst) begin
      own_v <= 1'b0;
      own <= REQ_A;
    end else if (state == ACK && (win ? b_lock : a_lock)) begin
      own_v <= 1'b1;
      own <= win;
    end else if (state == IDLE && !owned)
      own_v <= 1'b0;
`else
  assign mask = 2'b11;
`endif
  always_comb begin
    sel_we = grant ? b_we : a_we;
    state_nx = state == IDLE   ? (valid ? STROBE : IDLE) :
               state == STROBE ? (gb_wen ? ACK : RWAIT) :
               state == RWAIT  ? (cnt == '0 ? ACK : RWAIT) : IDLE;
    a_ack = state == ACK && win == REQ_A;
    b_ack = state == ACK && win == REQ_B;
  end
  always_ff @(posedge gb_clk) state <= gb_rst ? IDLE : state_nx;
  always_ff @(posedge gb_clk)
    if (gb_rst) begin
      {gb_wen, gb_rstb, win, cnt} <= '0;
      last <= REQ_B;
      gb_addr <= '0;
      gb_wdata <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      gb_wen <= state == IDLE && valid && sel_we;
      gb_rstb <= state == IDLE && valid && !sel_we;
      if (state == IDLE && valid) begin
        win <= grant;
        last <= grant;
        gb_addr <= grant ? b_addr : a_addr;
        gb_wdata <= grant ? b_wdata : a_wdata;
      end
      if (state == STROBE) cnt <= CW'(RD_DELAY - 1);
      else if (state == RWAIT) cnt <= cnt - CW'(1);
      if (state == RWAIT && cnt == '0 && win == REQ_A) a_rdata <= gb_rdata;
      if (state == RWAIT && cnt == '0 && win == REQ_B) b_rdata <= gb_rdata;
    end
endmodule

// File: tb/tb_ghostbus_arbiter.sv
// tb_ghostbus_arbiter: scoreboard and vector-table bench for ghostbus_arbiter
module tb_ghostbus_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RD = 2;
  localparam logic [31:0] XV = 32'h5A5A_ABCD;
  typedef struct {
    logic id;
    logic we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  typedef struct {
    logic ae;
    logic awe;
    logic [23:0] aad;
    logic [31:0] awd;
    logic be;
    logic bwe;
    logic [23:0] bad;
    logic [31:0] bwd;
  } vec_t;
  logic gb_clk = 1'b0;
  logic gb_rst = 1'b1;
  always #5 gb_clk = ~gb_clk;
  logic a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, b_ack, gb_wen, gb_rstb;
  logic [DW-1:0] a_rdata, b_rdata, gb_wdata, gb_rdata;
  logic [AW-1:0] gb_addr;
`ifdef GHOSTBUS_ARB_LOCK_EN
  logic a_lock = 1'b0, b_lock = 1'b0;
`endif
  ghostbus_arbiter #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(RD)) u_dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
`ifdef GHOSTBUS_ARB_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb),
    .gb_rdata(gb_rdata)
  );
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] shadow [256] = '{default: 32'h0};
  logic [3:0] tmr = '0;
  logic [31:0] rv = '0;
  always @(posedge gb_clk) begin
    if (gb_wen) mem[gb_addr[7:0]] <= gb_wdata;
    if (gb_rstb) begin
      tmr <= 4'(RD);
      rv <= mem[gb_addr[7:0]];
    end else if (tmr != 0) tmr <= tmr - 4'd1;
  end
  assign gb_rdata = tmr == 4'd1 ? rv : 32'h0BAD_F00D;
  logic x1_req = 1'b0, x5_req = 1'b0;
  logic [AW-1:0] x_addr = 24'h00ABCD;
  logic x1_ack, x1_back, x1_wen, x1_rstb, x5_ack, x5_back, x5_wen, x5_rstb;
  logic [DW-1:0] x1_rdata, x1_brdata, x1_wdata, x1_gbr, x5_rdata, x5_brdata, x5_wdata, x5_gbr;
  logic [AW-1:0] x1_addr, x5_addr;
  logic [2:0] t1 = '0, t5 = '0;
  always @(posedge gb_clk) begin
    t1 <= x1_rstb ? 3'd1 : (t1 != 0 ? t1 - 3'd1 : 3'd0);
    t5 <= x5_rstb ? 3'd5 : (t5 != 0 ? t5 - 3'd1 : 3'd0);
  end
  assign x1_gbr = t1 == 3'd1 ? XV : 32'h0BAD_F00D;
  assign x5_gbr = t5 == 3'd1 ? XV : 32'h0BAD_F00D;
  ghostbus_arbiter #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(1)) u_dut1 (
    .gb_clk(gb_clk), .gb_rst(gb_rst),
    .a_req(x1_req), .b_req(1'b0), .a_we(1'b0), .b_we(1'b0),
    .a_addr(x_addr), .b_addr(24'h0), .a_wdata(32'h0), .b_wdata(32'h0),
`ifdef GHOSTBUS_ARB_LOCK_EN
    .a_lock(1'b0), .b_lock(1'b0),
`endif
    .a_ack(x1_ack), .b_ack(x1_back), .a_rdata(x1_rdata), .b_rdata(x1_brdata),
    .gb_addr(x1_addr), .gb_wdata(x1_wdata), .gb_wen(x1_wen), .gb_rstb(x1_rstb),
    .gb_rdata(x1_gbr)
  );
  ghostbus_arbiter #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(5)) u_dut5 (
    .gb_clk(gb_clk), .gb_rst(gb_rst),
    .a_req(x5_req), .b_req(1'b0), .a_we(1'b0), .b_we(1'b0),
    .a_addr(x_addr), .b_addr(24'h0), .a_wdata(32'h0), .b_wdata(32'h0),
`ifdef GHOSTBUS_ARB_LOCK_EN
    .a_lock(1'b0), .b_lock(1'b0),
`endif
    .a_ack(x5_ack), .b_ack(x5_back), .a_rdata(x5_rdata), .b_rdata(x5_brdata),
    .gb_addr(x5_addr), .gb_wdata(x5_wdata), .gb_wen(x5_wen), .gb_rstb(x5_rstb),
    .gb_rdata(x5_gbr)
  );
  int n_chk = 0;
  int n_fail = 0;
  txn_t sbq[$];
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic exp_last = 1'b1;
  logic prev_stb = 1'b0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input logic id, input logic we, input logic [23:0] ad, input logic [31:0] wd);
    txn_t t;
    t.id = id;
    t.we = we;
    t.addr = ad;
    t.wdata = wd;
    if (we) begin
      shadow[ad[7:0]] = wd;
      t.rdata = exp_rd[id];
    end else begin
      t.rdata = shadow[ad[7:0]];
      exp_rd[id] = t.rdata;
    end
    sbq.push_back(t);
    exp_last = id;
  endtask
  always @(negedge gb_clk) begin
    txn_t t;
    if (gb_wen || gb_rstb) begin
      check("strobe_overlap", 64'(gb_wen & gb_rstb), 64'd0);
      check("strobe_width", 64'(prev_stb), 64'd0);
      if (sbq.size() == 0) check("unexpected_strobe", 64'd1, 64'd0);
      else begin
        check("strobe_we", 64'(gb_wen), 64'(sbq[0].we));
        check("strobe_addr", 64'(gb_addr), 64'(sbq[0].addr));
        if (gb_wen) check("strobe_wdata", 64'(gb_wdata), 64'(sbq[0].wdata));
      end
    end
    prev_stb = gb_wen || gb_rstb;
    if (a_ack || b_ack) begin
      check("dual_ack", 64'(a_ack & b_ack), 64'd0);
      if (sbq.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
      else begin
        t = sbq.pop_front();
        check("ack_id", 64'(b_ack), 64'(t.id));
        check("ack_rdata", 64'(t.id ? b_rdata : a_rdata), 64'(t.rdata));
      end
    end
  end
  task automatic run(input vec_t v);
    logic first;
    @(negedge gb_clk);
    first = (v.ae && v.be) ? ~exp_last : v.be;
    if (!first) begin
      if (v.ae) push(1'b0, v.awe, v.aad, v.awd);
      if (v.be) push(1'b1, v.bwe, v.bad, v.bwd);
    end else begin
      push(1'b1, v.bwe, v.bad, v.bwd);
      if (v.ae) push(1'b0, v.awe, v.aad, v.awd);
    end
    {a_req, a_we, a_addr, a_wdata} = {v.ae, v.awe, v.aad, v.awd};
    {b_req, b_we, b_addr, b_wdata} = {v.be, v.bwe, v.bad, v.bwd};
    for (int i = 0; i < 40 && (a_req || b_req); i++) begin
      @(negedge gb_clk);
      if (a_ack) a_req = 1'b0;
      if (b_ack) b_req = 1'b0;
    end
    check("run_timeout", 64'(a_req | b_req), 64'd0);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask
  task automatic wait_ack(input logic id, input string nm);
    int n = 0;
    while (!(id ? b_ack : a_ack) && n < 30) begin
      @(negedge gb_clk);
      n++;
    end
    check(nm, 64'(n < 30), 64'd1);
  endtask
  task automatic do_reset();
    @(negedge gb_clk);
    gb_rst = 1'b1;
    repeat (2) @(negedge gb_clk);
    gb_rst = 1'b0;
    sbq.delete();
    exp_rd = '{32'h0, 32'h0};
    exp_last = 1'b1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t vt [8];
    vec_t v;
    int l1, l5;
    vt[0] = '{1'b1, 1'b1, 24'h30, 32'h1111_1111, 1'b1, 1'b1, 24'h31, 32'h2222_2222};
    vt[1] = '{1'b1, 1'b0, 24'h31, 32'h0, 1'b1, 1'b0, 24'h30, 32'h0};
    vt[2] = '{1'b1, 1'b1, 24'h32, 32'h3333_3333, 1'b1, 1'b0, 24'h10, 32'h0};
    vt[3] = '{1'b1, 1'b0, 24'h32, 32'h0, 1'b1, 1'b1, 24'h33, 32'h4444_4444};
    vt[4] = '{1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 1'b0, 24'h33, 32'h0};
    vt[5] = '{1'b1, 1'b0, 24'h30, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0};
    vt[6] = '{1'b1, 1'b1, 24'h34, 32'h5555_5555, 1'b1, 1'b0, 24'h34, 32'h0};
    vt[7] = '{1'b1, 1'b1, 24'h20, 32'h8888_8888, 1'b1, 1'b1, 24'h21, 32'h9999_9999};
    repeat (3) @(negedge gb_clk);
    check("rst_ctl", 64'({a_ack, b_ack, gb_wen, gb_rstb}), 64'd0);
    check("rst_bus", 64'({gb_addr, gb_wdata}), 64'd0);
    check("rst_rdata", {a_rdata, b_rdata}, 64'd0);
    gb_rst = 1'b0;
    @(negedge gb_clk);
    push(1'b0, 1'b1, 24'h10, 32'hDEAD_BEEF);
    {a_req, a_we, a_addr, a_wdata} = {1'b1, 1'b1, 24'h10, 32'hDEAD_BEEF};
    @(negedge gb_clk);
    check("wr_strobe", 64'({gb_wen, gb_rstb, a_ack}), 64'b100);
    check("wr_bus", 64'({gb_addr, gb_wdata}), {8'h0, 24'h10, 32'hDEAD_BEEF});
    @(negedge gb_clk);
    check("wr_ack", 64'({a_ack, b_ack, gb_wen}), 64'b100);
    a_req = 1'b0;
    @(negedge gb_clk);
    push(1'b1, 1'b0, 24'h10, 32'h0);
    {b_req, b_we, b_addr} = {1'b1, 1'b0, 24'h10};
    for (int i = 1; i <= RD + 2; i++) begin
      @(negedge gb_clk);
      check("rd_rstb", 64'(gb_rstb), 64'(i == 1));
      check("rd_ack", 64'({a_ack, b_ack}), 64'(i == RD + 2));
    end
    check("rd_data", 64'(b_rdata), 64'hDEAD_BEEF);
    b_req = 1'b0;
    for (int i = 0; i < 8; i++) run(vt[i]);
    @(negedge gb_clk);
    push(1'b0, 1'b0, 24'h30, 32'h0);
    {a_req, a_we, a_addr} = {1'b1, 1'b0, 24'h30};
    repeat (2) @(negedge gb_clk);
    gb_rst = 1'b1;
    @(negedge gb_clk);
    check("rwait_rst_ctl", 64'({a_ack, b_ack, gb_wen, gb_rstb}), 64'd0);
    check("rwait_rst_bus", 64'({gb_addr, gb_wdata}), 64'd0);
    check("rwait_rst_rdata", {a_rdata, b_rdata}, 64'd0);
    a_req = 1'b0;
    gb_rst = 1'b0;
    sbq.delete();
    exp_rd = '{32'h0, 32'h0};
    exp_last = 1'b1;
    v = '{1'b1, 1'b0, 24'h10, 32'h0, 1'b1, 1'b0, 24'h31, 32'h0};
    run(v);
    check("post_rst_a_rdata", 64'(a_rdata), 64'hDEAD_BEEF);
    @(negedge gb_clk);
    {x1_req, x5_req} = 2'b11;
    l1 = 0;
    l5 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge gb_clk);
      if (x1_ack && l1 == 0) begin
        l1 = i;
        x1_req = 1'b0;
        check("rd1_data", 64'(x1_rdata), 64'(XV));
      end
      if (x5_ack && l5 == 0) begin
        l5 = i;
        x5_req = 1'b0;
        check("rd5_data", 64'(x5_rdata), 64'(XV));
      end
    end
    check("rd1_latency", 64'(l1), 64'd3);
    check("rd5_latency", 64'(l5), 64'd7);
    {x1_req, x5_req} = 2'b00;
`ifdef GHOSTBUS_ARB_LOCK_EN
    do_reset();
    @(negedge gb_clk);
    a_lock = 1'b1;
    push(1'b0, 1'b0, 24'h20, 32'h0);
    push(1'b0, 1'b1, 24'h20, 32'h6666_6666);
    push(1'b1, 1'b1, 24'h21, 32'h7777_7777);
    {a_req, a_we, a_addr} = {1'b1, 1'b0, 24'h20};
    {b_req, b_we, b_addr, b_wdata} = {1'b1, 1'b1, 24'h21, 32'h7777_7777};
    wait_ack(1'b0, "lock_rd_ack");
    check("lock_rd_data", 64'(a_rdata), 64'h8888_8888);
    a_req = 1'b0;
    repeat (3) begin
      @(negedge gb_clk);
      check("lock_hold", 64'({gb_wen, gb_rstb, b_ack}), 64'd0);
    end
    {a_req, a_we, a_wdata} = {1'b1, 1'b1, 32'h6666_6666};
    wait_ack(1'b0, "lock_wr_ack");
    a_req = 1'b0;
    a_lock = 1'b0;
    wait_ack(1'b1, "lock_b_ack");
    b_req = 1'b0;
`endif
    repeat (3) @(negedge gb_clk);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
